pipe_control_unit: RTL
======================

Name: pipe_control_unit

Overview:
- Parametrised successor to the single-cycle main control decoder.
- Decodes the ID-stage opcode into a control bundle and carries it through the ID/EX, EX/MEM and MEM/WB control registers.
- Detects load-use hazards internally and inserts bubbles for hazard stalls, branch flushes and illegal opcodes.
- Sits beside the datapath pipeline registers. It replaces the separate hazard-detection and control-forwarding logic.

Parameters:
- REG_AW, 5, register address width.
- ALUOP_W, 2, ALUOp field width; the value is zero-extended from the 2-bit codes.
- CNT_W, 16, width of the saturating stall and flush event counters.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- op_i  in  7  opcode of the instruction in IF/ID.
- rs1_i  in  REG_AW  rs1 of the IF/ID instruction.
- rs2_i  in  REG_AW  rs2 of the IF/ID instruction.
- rd_i  in  REG_AW  rd of the IF/ID instruction.
- flush_i  in  1  branch taken, resolved in EX; squashes the IF/ID instruction.
- hold_i  in  1  global freeze, e.g. memory not ready.
- stall_o  out  1  combinational load-use stall; hold PC and IF/ID.
- ex_alusrc_o  out  1  EX-stage control.
- ex_aluop_o  out  ALUOP_W  EX-stage control.
- ex_branch_o  out  1  EX-stage control.
- ex_rd_o  out  REG_AW  rd held in the EX stage.
- mem_read_o  out  1  MEM-stage control.
- mem_write_o  out  1  MEM-stage control.
- mem_rd_o  out  REG_AW  rd held in the MEM stage.
- mem_regwrite_o  out  1  MEM-stage control.
- wb_regwrite_o  out  1  WB-stage control.
- wb_memtoreg_o  out  1  WB-stage control.
- wb_rd_o  out  REG_AW  rd held in the WB stage.
- illegal_o  out  1  registered; high for one EX-stage slot for an unknown opcode.
- stall_cnt_o  out  CNT_W  saturating count of load-use stall cycles.
- flush_cnt_o  out  CNT_W  saturating count of flush cycles.

Behaviour:
- Decode (combinational). Bundle order is {alusrc, aluop, branch, memread, memwrite, regwrite, memtoreg}.
  - R-type 0110011: {0, 10, 0, 0, 0, 1, 0}.
  - I-ALU 0010011: {1, 00, 0, 0, 0, 1, 0}.
  - LOAD 0000011: {1, 00, 0, 1, 0, 1, 1}.
  - STORE 0100011: {1, 00, 0, 0, 1, 0, 0}.
  - BRANCH 1100011: {0, 01, 0→1 branch, 0, 0, 0, 0}.
  - Any other opcode: all zero, and the illegal flag is set.
- rs1 is "used" by R, I-ALU, LOAD, STORE and BRANCH. rs2 is "used" by R, STORE and BRANCH.
- stall_o = ex_memread AND ex_rd≠0 AND ((used_rs1 AND ex_rd==rs1_i) OR (used_rs2 AND ex_rd==rs2_i)) AND NOT hold_i.
- Each stage is one cycle. The control bundle of an instruction appears on the ex_* outputs one cycle after the edge on which it was in ID. It reaches mem_* one cycle later and wb_* one cycle after that.
- Update priority at each edge:
  - hold_i=1: every stage register holds and the counters hold.
  - Otherwise, flush_i=1 or stall_o=1: ID/EX loads a bubble (all controls 0, rd 0, illegal 0); EX/MEM and MEM/WB advance normally.
  - Otherwise: ID/EX loads the decoded bundle, rd_i and the illegal flag.
- An illegal opcode enters ID/EX as a bubble with illegal=1. illegal_o is cleared when that slot advances.
- When flush_i and stall_o are both high, count only the flush; stall_cnt_o does not increment.
- Counters saturate at 2^CNT_W−1 and never wrap.
- Reset (rst_i low, asynchronous): every stage register, illegal_o and both counters go to 0. Every registered output reads 0 while reset is asserted. Deasserting reset mid-program starts from an empty pipeline.
- An x0 destination never causes a stall.

Test Plan:
- Reset mid-stream: drive LOAD then R-type, assert rst_i=0 asynchronously between edges → all outputs 0 immediately; after release, the pipeline refills with a 3-cycle latency to wb_*.
- Load-use: LOAD rd=5, then R-type rs1=5 → stall_o=1 for exactly one cycle, one bubble in EX, stall_cnt_o=1. Same sequence with rd=0 → no stall.
- Store after load: LOAD rd=7, then STORE rs2=7 → stall. LOAD rd=7, then I-ALU rs2 field=7 → no stall, because rs2 is unused.
- Flush while stalled: flush_i=1 in the same cycle stall_o=1 → a single bubble, flush_cnt_o=1, stall_cnt_o=0.
- Hold: hold_i=1 for 3 cycles mid-pipeline → all ex/mem/wb outputs are frozen and stall_o=0; they resume unchanged when hold_i drops.
- Illegal opcode 1111111 → illegal_o=1 for one EX slot; mem_write_o and wb_regwrite_o stay 0 for that slot. With CNT_W=2 and 5 flushes → flush_cnt_o saturates at 3.

Source files
------------

// File: rtl/pipe_control_unit_if.sv
// pipe_control_unit_if: decode inputs and pipelined control outputs of the control unit
interface pipe_control_unit_if #(
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 2,
    parameter int CNT_W   = 16
);
    logic [6:0]         op_i;
    logic [REG_AW-1:0]  rs1_i;
    logic [REG_AW-1:0]  rs2_i;
    logic [REG_AW-1:0]  rd_i;
    logic               flush_i;
    logic               hold_i;
    logic               stall_o;
    logic               ex_alusrc_o;
    logic [ALUOP_W-1:0] ex_aluop_o;
    logic               ex_branch_o;
    logic [REG_AW-1:0]  ex_rd_o;
    logic               mem_read_o;
    logic               mem_write_o;
    logic [REG_AW-1:0]  mem_rd_o;
    logic               mem_regwrite_o;
    logic               wb_regwrite_o;
    logic               wb_memtoreg_o;
    logic [REG_AW-1:0]  wb_rd_o;
    logic               illegal_o;
    logic [CNT_W-1:0]   stall_cnt_o;
    logic [CNT_W-1:0]   flush_cnt_o;

    modport master (
        output op_i, rs1_i, rs2_i, rd_i, flush_i, hold_i,
        input  stall_o, ex_alusrc_o, ex_aluop_o, ex_branch_o, ex_rd_o,
               mem_read_o, mem_write_o, mem_rd_o, mem_regwrite_o,
               wb_regwrite_o, wb_memtoreg_o, wb_rd_o, illegal_o,
               stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  op_i, rs1_i, rs2_i, rd_i, flush_i, hold_i,
        output stall_o, ex_alusrc_o, ex_aluop_o, ex_branch_o, ex_rd_o,
               mem_read_o, mem_write_o, mem_rd_o, mem_regwrite_o,
               wb_regwrite_o, wb_memtoreg_o, wb_rd_o, illegal_o,
               stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/pipe_control_unit.sv
// pipe_control_unit: opcode decode, load-use hazard detection and ID/EX, EX/MEM, MEM/WB control registers
module pipe_control_unit #(
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 2,
    parameter int CNT_W   = 16
) (
    input logic              clk_i,
    input logic              rst_i,
    pipe_control_unit_if.slave bus
);
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    logic               is_r, is_i, is_ld, is_st, is_br;
    logic               dec_illegal, use_rs1, use_rs2, stall, bubble;
    logic               nx_alusrc, nx_branch, nx_memread, nx_memwrite, nx_regwrite, nx_memtoreg, nx_illegal;
    logic [ALUOP_W-1:0] nx_aluop;
    logic [REG_AW-1:0]  nx_rd;

    logic               ex_alusrc, ex_branch, ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg, illegal;
    logic [ALUOP_W-1:0] ex_aluop;
    logic [REG_AW-1:0]  ex_rd;
    logic               mem_read, mem_write, mem_regwrite, mem_memtoreg;
    logic [REG_AW-1:0]  mem_rd;
    logic               wb_regwrite, wb_memtoreg;
    logic [REG_AW-1:0]  wb_rd;
    logic [CNT_W-1:0]   stall_cnt, flush_cnt;

    // Decode the ID opcode, detect load-use hazards and form the next ID/EX contents
    always_comb begin
        is_r        = bus.op_i == OP_R;
        is_i        = bus.op_i == OP_I;
        is_ld       = bus.op_i == OP_LD;
        is_st       = bus.op_i == OP_ST;
        is_br       = bus.op_i == OP_BR;
        use_rs1     = is_r | is_i | is_ld | is_st | is_br;
        use_rs2     = is_r | is_st | is_br;
        dec_illegal = ~use_rs1;
        stall       = ex_memread && ex_rd != '0 &&
                      ((use_rs1 && ex_rd == bus.rs1_i) || (use_rs2 && ex_rd == bus.rs2_i)) && !bus.hold_i;
        bubble      = bus.flush_i | stall;
        nx_alusrc   = ~bubble & (is_i | is_ld | is_st);
        nx_aluop    = bubble ? '0 : is_r ? ALUOP_W'(2'b10) : is_br ? ALUOP_W'(2'b01) : '0;
        nx_branch   = ~bubble & is_br;
        nx_memread  = ~bubble & is_ld;
        nx_memwrite = ~bubble & is_st;
        nx_regwrite = ~bubble & (is_r | is_i | is_ld);
        nx_memtoreg = ~bubble & is_ld;
        nx_illegal  = ~bubble & dec_illegal;
        nx_rd       = (bubble | dec_illegal) ? '0 : bus.rd_i;
    end

    // ID/EX register: loads the decoded bundle or a bubble, frozen by hold
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            {ex_alusrc, ex_aluop, ex_branch, ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg, ex_rd, illegal} <= '0;
        end else if (!bus.hold_i) begin
            {ex_alusrc, ex_aluop, ex_branch, ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg, ex_rd, illegal} <=
                {nx_alusrc, nx_aluop, nx_branch, nx_memread, nx_memwrite, nx_regwrite, nx_memtoreg, nx_rd, nx_illegal};
        end
    end

    // EX/MEM and MEM/WB registers: advance every unheld cycle, bubbles included
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            {mem_read, mem_write, mem_regwrite, mem_memtoreg, mem_rd} <= '0;
            {wb_regwrite, wb_memtoreg, wb_rd} <= '0;
        end else if (!bus.hold_i) begin
            {mem_read, mem_write, mem_regwrite, mem_memtoreg, mem_rd} <=
                {ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg, ex_rd};
            {wb_regwrite, wb_memtoreg, wb_rd} <= {mem_regwrite, mem_memtoreg, mem_rd};
        end
    end

    // Saturating event counters; a flush coinciding with a stall counts only as a flush
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (!bus.hold_i) begin
            if (bus.flush_i) flush_cnt <= (flush_cnt == '1) ? flush_cnt : flush_cnt + 1'b1;
            else if (stall) stall_cnt <= (stall_cnt == '1) ? stall_cnt : stall_cnt + 1'b1;
        end
    end

    assign bus.stall_o        = stall;
    assign bus.ex_alusrc_o    = ex_alusrc;
    assign bus.ex_aluop_o     = ex_aluop;
    assign bus.ex_branch_o    = ex_branch;
    assign bus.ex_rd_o        = ex_rd;
    assign bus.mem_read_o     = mem_read;
    assign bus.mem_write_o    = mem_write;
    assign bus.mem_rd_o       = mem_rd;
    assign bus.mem_regwrite_o = mem_regwrite;
    assign bus.wb_regwrite_o  = wb_regwrite;
    assign bus.wb_memtoreg_o  = wb_memtoreg;
    assign bus.wb_rd_o        = wb_rd;
    assign bus.illegal_o      = illegal;
    assign bus.stall_cnt_o    = stall_cnt;
    assign bus.flush_cnt_o    = flush_cnt;
endmodule
